// File: rtl/mul_diff_widths_sched.sv
// Two-requester round-robin scheduler that time-shares one multiplier datapath.
// Operands of the granted requester are registered onto mul_a/mul_b. Each issue
// carries a tag down a fixed-latency pipeline, so res_valid fires in the cycle
// the datapath presents that operation's result. Per-requester credits block
// issue while the consumer's result buffer is full.
module mul_diff_widths_sched #(
    parameter int NUM_ELEMENTS = 34,
    parameter int BIT_LEN      = 17,
    parameter int MUL_LATENCY  = 3,
    parameter int CREDITS      = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [1:0]                           req_valid,
    output logic [1:0]                           req_ready,
    input  logic [NUM_ELEMENTS*BIT_LEN-1:0]      req_a0,
    input  logic [NUM_ELEMENTS*BIT_LEN-1:0]      req_b0,
    input  logic [NUM_ELEMENTS*BIT_LEN-1:0]      req_a1,
    input  logic [NUM_ELEMENTS*BIT_LEN-1:0]      req_b1,
    output logic [NUM_ELEMENTS*BIT_LEN-1:0]      mul_a,
    output logic [NUM_ELEMENTS*BIT_LEN-1:0]      mul_b,
    output logic [1:0]                           res_valid,
    input  logic [1:0]                           credit_return,
    output logic [$clog2(MUL_LATENCY+1)-1:0]     in_flight,
    output logic                                 busy
);

    localparam int W   = NUM_ELEMENTS * BIT_LEN;
    localparam int CW  = $clog2(CREDITS + 1);
    localparam int IFW = $clog2(MUL_LATENCY + 1);

    // Registered state
    logic [W-1:0]           mul_a_q, mul_a_d;
    logic [W-1:0]           mul_b_q, mul_b_d;
    logic [MUL_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [MUL_LATENCY-1:0] tag_id_q, tag_id_d;
    logic [1:0]             res_valid_q, res_valid_d;
    logic [CW-1:0]          credit_q [2];
    logic [CW-1:0]          credit_d [2];
    logic                   ptr_q, ptr_d;
    logic [IFW-1:0]         in_flight_q, in_flight_d;

    // Combinational grant signals
    logic [1:0]             eligible;
    logic [1:0]             grant;
    logic                   hs;
    logic                   gid;

    // Round-robin arbitration among requesters that have work and a free result slot.
    always_comb begin
        eligible = req_valid & {(credit_q[1] != '0), (credit_q[0] != '0)};
        grant    = 2'b00;
        if (!reset) begin
            if (eligible == 2'b11) begin
                grant[ptr_q] = 1'b1;
            end else begin
                grant = eligible;
            end
        end
        hs  = |grant;
        gid = grant[1];
    end

    assign req_ready = grant;

    // Next-state for operands, tag pipeline, credits, pointer and occupancy.
    always_comb begin
        // Operands only move on issue so the datapath stays quiet when idle.
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (hs) begin
            mul_a_d = gid ? req_a1 : req_a0;
            mul_b_d = gid ? req_b1 : req_b0;
        end

        // Tag shift register: a bubble (vld=0) enters on idle cycles.
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = hs;
        tag_id_d[0]  = gid;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        // The tag leaving the last stage becomes the one-cycle result strobe.
        res_valid_d = 2'b00;
        if (tag_vld_q[MUL_LATENCY-1]) begin
            res_valid_d[tag_id_q[MUL_LATENCY-1]] = 1'b1;
        end

        // Credit is spent at issue; a simultaneous return cancels it out,
        // and returns beyond the full count are dropped.
        for (int r = 0; r < 2; r++) begin
            credit_d[r] = credit_q[r];
            if (grant[r] && !credit_return[r]) begin
                credit_d[r] = credit_q[r] - CW'(1);
            end else if (!grant[r] && credit_return[r] && (credit_q[r] != CW'(CREDITS))) begin
                credit_d[r] = credit_q[r] + CW'(1);
            end
        end

        // The pointer favours whoever lost (or did not compete) this time.
        ptr_d = hs ? ~gid : ptr_q;

        // Occupancy counts valid tags still inside the pipeline.
        in_flight_d = in_flight_q + IFW'(hs) - IFW'(tag_vld_q[MUL_LATENCY-1]);
    end

    // State update with synchronous reset; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            res_valid_q <= 2'b00;
            credit_q[0] <= CW'(CREDITS);
            credit_q[1] <= CW'(CREDITS);
            ptr_q       <= 1'b0;
            in_flight_q <= '0;
        end else begin
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            res_valid_q <= res_valid_d;
            credit_q[0] <= credit_d[0];
            credit_q[1] <= credit_d[1];
            ptr_q       <= ptr_d;
            in_flight_q <= in_flight_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_valid = res_valid_q;
    assign in_flight = in_flight_q;
    assign busy      = (in_flight_q != '0);

endmodule
